// File: rtl/msi_mem_ctrl.sv
// Main-memory controller behind the coherent bus: fixed-latency reads, FLUSH
// writes, and MSI intervention that replaces a pending read's memory response.
module msi_mem_ctrl #(
    parameter int ADDR_BITS   = 11,
    parameter int DATA_BITS   = 16,
    parameter int MEM_LATENCY = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 bus_valid,
    input  logic [1:0]           bus_cmd,
    input  logic [ADDR_BITS-1:0] bus_addr,
    input  logic [DATA_BITS-1:0] bus_data,
    output logic                 bus_ready,
    input  logic                 snoop_flush,
    input  logic [DATA_BITS-1:0] snoop_data,
    output logic                 resp_valid,
    output logic [ADDR_BITS-1:0] resp_addr,
    output logic [DATA_BITS-1:0] resp_data,
    output logic                 wr_done,
    output logic                 intervened
);
    localparam logic [1:0] CMD_IDLE  = 2'b00;
    localparam logic [1:0] CMD_FLUSH = 2'b11;

    typedef enum logic [1:0] {S_IDLE, S_RD_WAIT, S_RD_RESP, S_WR_ACK} state_t;

    state_t                 r_state;
    state_t                 w_state_next;
    logic [3:0]             r_cnt;
    logic [3:0]             w_cnt_next;
    logic [ADDR_BITS-1:0]   r_addr;
    logic                   r_abort;
    logic                   r_active;
    logic [ADDR_BITS-1:0]   r_hold_addr;
    logic [DATA_BITS-1:0]   r_hold_data;
    logic [DATA_BITS-1:0]   r_rd_q;
    logic [DATA_BITS-1:0]   r_mem [0:(2**ADDR_BITS)-1];

    logic                   w_ready;
    logic                   w_accept;
    logic                   w_accept_rd;
    logic                   w_snoop_wr;
    logic                   w_we;
    logic [ADDR_BITS-1:0]   w_waddr;
    logic [DATA_BITS-1:0]   w_wdata;
    logic [ADDR_BITS-1:0]   w_raddr;
    logic                   w_resp_valid;

    // r_active keeps bus_ready low until the first edge after reset is released
    assign w_ready      = r_active && (r_state == S_IDLE);
    assign w_accept     = bus_valid && w_ready && (bus_cmd != CMD_IDLE);
    assign w_accept_rd  = w_accept && (bus_cmd != CMD_FLUSH);
    assign w_snoop_wr   = (r_state == S_RD_WAIT) && snoop_flush;
    assign w_resp_valid = (r_state == S_RD_RESP) && !r_abort;

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    if (bus_cmd == CMD_FLUSH) begin
                        w_state_next = S_WR_ACK;
                    end else begin
                        w_cnt_next   = 4'(MEM_LATENCY - 1);
                        w_state_next = (MEM_LATENCY == 1) ? S_RD_RESP : S_RD_WAIT;
                    end
                end
            end
            S_RD_WAIT: begin
                w_cnt_next = r_cnt - 4'd1;
                if (r_cnt == 4'd1) begin
                    w_state_next = S_RD_RESP;
                end
            end
            S_RD_RESP: w_state_next = S_IDLE;
            S_WR_ACK:  w_state_next = S_IDLE;
            default:   w_state_next = S_IDLE;
        endcase
    end

    // Single write port shared by FLUSH (only in IDLE) and snoop data (only in RD_WAIT)
    always_comb begin
        w_we    = 1'b0;
        w_waddr = bus_addr;
        w_wdata = bus_data;
        if (w_accept && (bus_cmd == CMD_FLUSH)) begin
            w_we = 1'b1;
        end else if (w_snoop_wr) begin
            w_we    = 1'b1;
            w_waddr = r_addr;
            w_wdata = snoop_data;
        end
    end

    // In IDLE the read port follows the bus so a latency-1 read has data in RD_RESP
    assign w_raddr = (r_state == S_IDLE) ? bus_addr : r_addr;

    always_ff @(posedge clk) begin
        if (w_we) begin
            r_mem[w_waddr] <= w_wdata;
        end
        r_rd_q <= r_mem[w_raddr];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_cnt       <= 4'd0;
            r_addr      <= '0;
            r_abort     <= 1'b0;
            r_active    <= 1'b0;
            r_hold_addr <= '0;
            r_hold_data <= '0;
        end else begin
            r_state  <= w_state_next;
            r_cnt    <= w_cnt_next;
            r_active <= 1'b1;
            if (w_accept_rd) begin
                r_addr  <= bus_addr;
                r_abort <= 1'b0;
            end else if (w_snoop_wr) begin
                r_abort <= 1'b1;
            end
            if (w_resp_valid) begin
                r_hold_addr <= r_addr;
                r_hold_data <= r_rd_q;
            end
        end
    end

    assign bus_ready  = w_ready;
    assign resp_valid = w_resp_valid;
    assign resp_addr  = w_resp_valid ? r_addr : r_hold_addr;
    assign resp_data  = w_resp_valid ? r_rd_q : r_hold_data;
    assign wr_done    = (r_state == S_WR_ACK);
    assign intervened = (r_state == S_RD_RESP) && r_abort;

endmodule

// File: tb/tb_msi_mem_ctrl.sv
// Scoreboard bench for msi_mem_ctrl: the latency-4 instance is checked against
// a queue of expected events; latency-1 and latency-15 instances check timing.
module tb_msi_mem_ctrl;
    localparam int AW = 11;
    localparam int DW = 16;
    localparam int LAT4 = 4;

    localparam logic [1:0] C_IDLE = 2'b00;
    localparam logic [1:0] C_RD   = 2'b01;
    localparam logic [1:0] C_RDX  = 2'b10;
    localparam logic [1:0] C_FL   = 2'b11;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          bus_valid = 1'b0;
    logic [1:0]    bus_cmd = 2'b00;
    logic [AW-1:0] bus_addr = '0;
    logic [DW-1:0] bus_data = '0;
    logic          snoop_flush = 1'b0;
    logic [DW-1:0] snoop_data = '0;

    logic          rdy4, rv4, wd4, iv4;
    logic [AW-1:0] ra4;
    logic [DW-1:0] rd4;
    logic          rdy1, rv1, wd1, iv1;
    logic [AW-1:0] ra1;
    logic [DW-1:0] rd1;
    logic          rdy15, rv15, wd15, iv15;
    logic [AW-1:0] ra15;
    logic [DW-1:0] rd15;

    msi_mem_ctrl #(.ADDR_BITS(AW), .DATA_BITS(DW), .MEM_LATENCY(4)) u_lat4 (
        .clk(clk), .rst(rst), .bus_valid(bus_valid), .bus_cmd(bus_cmd),
        .bus_addr(bus_addr), .bus_data(bus_data), .bus_ready(rdy4),
        .snoop_flush(snoop_flush), .snoop_data(snoop_data),
        .resp_valid(rv4), .resp_addr(ra4), .resp_data(rd4),
        .wr_done(wd4), .intervened(iv4));

    msi_mem_ctrl #(.ADDR_BITS(AW), .DATA_BITS(DW), .MEM_LATENCY(1)) u_lat1 (
        .clk(clk), .rst(rst), .bus_valid(bus_valid), .bus_cmd(bus_cmd),
        .bus_addr(bus_addr), .bus_data(bus_data), .bus_ready(rdy1),
        .snoop_flush(snoop_flush), .snoop_data(snoop_data),
        .resp_valid(rv1), .resp_addr(ra1), .resp_data(rd1),
        .wr_done(wd1), .intervened(iv1));

    msi_mem_ctrl #(.ADDR_BITS(AW), .DATA_BITS(DW), .MEM_LATENCY(15)) u_lat15 (
        .clk(clk), .rst(rst), .bus_valid(bus_valid), .bus_cmd(bus_cmd),
        .bus_addr(bus_addr), .bus_data(bus_data), .bus_ready(rdy15),
        .snoop_flush(snoop_flush), .snoop_data(snoop_data),
        .resp_valid(rv15), .resp_addr(ra15), .resp_data(rd15),
        .wr_done(wd15), .intervened(iv15));

    always #5 clk = ~clk;

    // kind: 0 read response, 1 write done, 2 intervened
    typedef struct {
        int            kind;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        int            due;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;
    int   ncyc = 0;

    task automatic tick();
        @(negedge clk);
        ncyc++;
    endtask

    function automatic exp_t pop_exp();
        exp_t e;
        e.kind = -2; e.addr = '0; e.data = '0; e.due = -1;
        if (sb_q.size() != 0) e = sb_q.pop_front();
        return e;
    endfunction

    // Waits for the latency-4 instance to become ready, issues one request and
    // records the expected outcome in the scoreboard.
    task automatic send(input logic [1:0] cmd, input logic [AW-1:0] a,
                        input logic [DW-1:0] d, input int kind, input logic [DW-1:0] ed);
        exp_t e;
        int w;
        w = 0;
        while (!rdy4 && w < 50) begin
            tick();
            w++;
        end
        if (!rdy4) begin
            errors++;
            $display("FAIL send_timeout: bus_ready %0b after %0d cycles, want 1", rdy4, w);
        end
        bus_valid = 1'b1; bus_cmd = cmd; bus_addr = a; bus_data = d;
        e.kind = kind; e.addr = a; e.data = ed;
        e.due  = ncyc + ((kind == 1) ? 1 : LAT4);
        sb_q.push_back(e);
        tick();
        bus_valid = 1'b0; bus_cmd = C_IDLE;
    endtask

    // Observes the latency-4 instance until its next strobe; returns what it saw.
    task automatic get_event(input int max_cyc, output int kind, output logic [AW-1:0] a,
                             output logic [DW-1:0] d, output int at, output bit busy_ok);
        int n;
        kind = -1; a = '0; d = '0; at = -1; busy_ok = 1'b1;
        for (int i = 0; i < max_cyc; i++) begin
            if (rdy4) busy_ok = 1'b0;
            n = int'(rv4) + int'(wd4) + int'(iv4);
            if (n != 0) begin
                kind = (n > 1) ? 3 : (rv4 ? 0 : (wd4 ? 1 : 2));
                a = ra4; d = rd4; at = ncyc;
                $display("txn kind=%0d addr=%h data=%h cyc=%0d", kind, a, d, at);
                return;
            end
            tick();
        end
        $display("txn timeout after %0d cycles at cyc=%0d", max_cyc, ncyc);
    endtask

    task automatic test_reset();
        int k, t; logic [AW-1:0] a; logic [DW-1:0] d; bit bz; exp_t e;
        rst = 1'b1;
        tick(); tick(); tick();
        checks++;
        if ({rdy4, rv4, wd4, iv4, ra4, rd4} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got rdy=%b rv=%b wd=%b iv=%b addr=%h data=%h, want all 0",
                     rdy4, rv4, wd4, iv4, ra4, rd4);
        end
        rst = 1'b0;
        checks++;
        if (rdy4 !== 1'b0) begin errors++; $display("FAIL reset_ready_low: got %b want 0", rdy4); end
        tick();
        checks++;
        if (rdy4 !== 1'b1) begin errors++; $display("FAIL reset_ready_high: got %b want 1", rdy4); end
        send(C_RD, 11'h040, 16'h0000, 0, 16'h0000);
        get_event(20, k, a, d, t, bz);
        e = pop_exp();
        checks++;
        if (k !== e.kind || t !== e.due) begin
            errors++;
            $display("FAIL first_read_timing: got kind %0d at cyc %0d, want kind %0d at cyc %0d", k, t, e.kind, e.due);
        end
        checks++;
        if (a !== e.addr || d !== e.data) begin
            errors++;
            $display("FAIL first_read_data: got addr %h data %h, want addr %h data %h", a, d, e.addr, e.data);
        end
        checks++;
        if (!bz) begin errors++; $display("FAIL first_read_busy: bus_ready went 1 while busy, want 0"); end
    endtask

    task automatic test_write_read();
        logic [1:0]    cmds [3] = '{C_FL, C_RDX, C_RD};
        logic [AW-1:0] adrs [3] = '{11'h0C0, 11'h0C0, 11'h080};
        logic [DW-1:0] wdat [3] = '{16'h5678, 16'h0000, 16'h0000};
        logic [DW-1:0] edat [3] = '{16'h0000, 16'h5678, 16'h0000};
        int            kinds[3] = '{1, 0, 0};
        int k, t; logic [AW-1:0] a; logic [DW-1:0] d; bit bz; exp_t e;
        for (int i = 0; i < 3; i++) begin
            send(cmds[i], adrs[i], wdat[i], kinds[i], edat[i]);
            get_event(20, k, a, d, t, bz);
            e = pop_exp();
            checks++;
            if (k !== e.kind || t !== e.due) begin
                errors++;
                $display("FAIL wr_rd_timing%0d: got kind %0d at cyc %0d, want kind %0d at cyc %0d", i, k, t, e.kind, e.due);
            end
            checks++;
            if (e.kind == 0 && (a !== e.addr || d !== e.data)) begin
                errors++;
                $display("FAIL wr_rd_data%0d: got addr %h data %h, want addr %h data %h", i, a, d, e.addr, e.data);
            end
        end
    endtask

    task automatic test_intervention();
        int k, t; logic [AW-1:0] a; logic [DW-1:0] d; bit bz; exp_t e;
        send(C_RD, 11'h400, 16'h0000, 2, 16'h0000);
        tick();
        snoop_flush = 1'b1; snoop_data = 16'hBEEF;
        tick();
        snoop_flush = 1'b0; snoop_data = 16'h0000;
        get_event(20, k, a, d, t, bz);
        e = pop_exp();
        checks++;
        if (k !== e.kind || t !== e.due) begin
            errors++;
            $display("FAIL intervene_strobe: got kind %0d at cyc %0d, want kind %0d at cyc %0d", k, t, e.kind, e.due);
        end
        send(C_RD, 11'h400, 16'h0000, 0, 16'hBEEF);
        get_event(20, k, a, d, t, bz);
        e = pop_exp();
        checks++;
        if (k !== e.kind || t !== e.due || a !== e.addr || d !== e.data) begin
            errors++;
            $display("FAIL intervene_readback: got kind %0d cyc %0d addr %h data %h, want kind %0d cyc %0d addr %h data %h",
                     k, t, a, d, e.kind, e.due, e.addr, e.data);
        end
    endtask

    task automatic test_busy_reject();
        int k, t, rd_at, fl_at; logic [AW-1:0] a; logic [DW-1:0] d; bit bz; exp_t e, fe;
        rd_at = -1; fl_at = -1;
        send(C_RD, 11'h100, 16'h0000, 0, 16'h0000);
        bus_valid = 1'b1; bus_cmd = C_FL; bus_addr = 11'h100; bus_data = 16'hDEAD;
        for (int i = 0; i < 30 && fl_at < 0; i++) begin
            if (rv4) begin
                rd_at = ncyc;
                e = pop_exp();
                $display("txn kind=0 addr=%h data=%h cyc=%0d", ra4, rd4, ncyc);
                checks++;
                if (ncyc !== e.due || ra4 !== e.addr || rd4 !== e.data) begin
                    errors++;
                    $display("FAIL busy_read: got cyc %0d addr %h data %h, want cyc %0d addr %h data %h",
                             ncyc, ra4, rd4, e.due, e.addr, e.data);
                end
            end
            if (rdy4) begin
                fl_at = ncyc;
                fe.kind = 1; fe.addr = 11'h100; fe.data = 16'h0000; fe.due = ncyc + 1;
                sb_q.push_back(fe);
            end
            tick();
        end
        bus_valid = 1'b0; bus_cmd = C_IDLE;
        checks++;
        if (rd_at < 0 || fl_at !== rd_at + 1) begin
            errors++;
            $display("FAIL busy_accept_cycle: got flush accept cyc %0d, want %0d", fl_at, rd_at + 1);
        end
        get_event(20, k, a, d, t, bz);
        e = pop_exp();
        checks++;
        if (k !== e.kind || t !== e.due) begin
            errors++;
            $display("FAIL busy_flush_done: got kind %0d at cyc %0d, want kind %0d at cyc %0d", k, t, e.kind, e.due);
        end
        send(C_RD, 11'h100, 16'h0000, 0, 16'hDEAD);
        get_event(20, k, a, d, t, bz);
        e = pop_exp();
        checks++;
        if (k !== e.kind || t !== e.due || d !== e.data) begin
            errors++;
            $display("FAIL busy_readback: got kind %0d cyc %0d data %h, want kind %0d cyc %0d data %h",
                     k, t, d, e.kind, e.due, e.data);
        end
    endtask

    task automatic test_reset_mid();
        int k, t, stray; logic [AW-1:0] a; logic [DW-1:0] d; bit bz; exp_t e;
        send(C_RD, 11'h200, 16'h0000, 0, 16'h0000);
        void'(pop_exp());
        tick();
        rst = 1'b1;
        tick();
        checks++;
        if (rdy4 !== 1'b0 || rv4 !== 1'b0 || wd4 !== 1'b0 || iv4 !== 1'b0) begin
            errors++;
            $display("FAIL midreset_outputs: got rdy=%b rv=%b wd=%b iv=%b, want all 0", rdy4, rv4, wd4, iv4);
        end
        rst = 1'b0;
        tick();
        checks++;
        if (rdy4 !== 1'b1) begin errors++; $display("FAIL midreset_ready: got %b want 1", rdy4); end
        stray = 0;
        for (int i = 0; i < 8; i++) begin
            if (rv4 || wd4 || iv4) stray++;
            tick();
        end
        checks++;
        if (stray != 0) begin errors++; $display("FAIL midreset_stray: got %0d strobes, want 0", stray); end
        send(C_RD, 11'h200, 16'h0000, 0, 16'h0000);
        get_event(20, k, a, d, t, bz);
        e = pop_exp();
        checks++;
        if (k !== e.kind || t !== e.due || a !== e.addr || d !== e.data) begin
            errors++;
            $display("FAIL midreset_reread: got kind %0d cyc %0d addr %h data %h, want kind %0d cyc %0d addr %h data %h",
                     k, t, a, d, e.kind, e.due, e.addr, e.data);
        end
    endtask

    task automatic test_latency_sweep();
        int acc, bad, t1, t4, t15;
        logic [DW-1:0] d1, d4, d15;
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
        tick();
        bus_valid = 1'b1; bus_cmd = C_IDLE; bus_addr = 11'h7FF; bus_data = 16'h1111;
        tick();
        bus_valid = 1'b0;
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            if (rv1 || wd1 || iv1 || rv4 || wd4 || iv4 || rv15 || wd15 || iv15) bad++;
            if (!(rdy1 && rdy4 && rdy15)) bad++;
            tick();
        end
        checks++;
        if (bad != 0) begin errors++; $display("FAIL idle_cmd_ignored: got %0d bad cycles, want 0", bad); end
        bus_valid = 1'b1; bus_cmd = C_FL; bus_addr = 11'h7FF; bus_data = 16'hA5A5;
        tick();
        bus_valid = 1'b0; bus_cmd = C_IDLE;
        $display("txn sweep flush addr=7ff wd=%b%b%b cyc=%0d", wd1, wd4, wd15, ncyc);
        checks++;
        if ({wd1, wd4, wd15} !== 3'b111) begin
            errors++;
            $display("FAIL sweep_wr_done: got %b want 111", {wd1, wd4, wd15});
        end
        tick();
        bus_valid = 1'b1; bus_cmd = C_RD; bus_addr = 11'h7FF;
        acc = ncyc;
        tick();
        bus_valid = 1'b0; bus_cmd = C_IDLE;
        t1 = -1; t4 = -1; t15 = -1; d1 = '0; d4 = '0; d15 = '0;
        for (int i = 0; i < 20; i++) begin
            if (rv1 && t1 < 0) begin t1 = ncyc; d1 = rd1; end
            if (rv4 && t4 < 0) begin t4 = ncyc; d4 = rd4; end
            if (rv15 && t15 < 0) begin t15 = ncyc; d15 = rd15; end
            tick();
        end
        $display("txn sweep read addr=7ff lat1@%0d lat4@%0d lat15@%0d", t1 - acc, t4 - acc, t15 - acc);
        checks++;
        if (t1 !== acc + 1 || d1 !== 16'hA5A5) begin
            errors++;
            $display("FAIL lat1_read: got delay %0d data %h, want delay 1 data a5a5", t1 - acc, d1);
        end
        checks++;
        if (t4 !== acc + 4 || d4 !== 16'hA5A5) begin
            errors++;
            $display("FAIL lat4_read: got delay %0d data %h, want delay 4 data a5a5", t4 - acc, d4);
        end
        checks++;
        if (t15 !== acc + 15 || d15 !== 16'hA5A5) begin
            errors++;
            $display("FAIL lat15_read: got delay %0d data %h, want delay 15 data a5a5", t15 - acc, d15);
        end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_intervention();
        test_busy_reject();
        test_reset_mid();
        test_latency_sweep();
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending, want 0", sb_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
